pwm_capture: RTL and testbench

// Decodes an external PWM waveform into period and high-time counts in clk cycles.

---
 rtl/pwm_capture.sv | 125 ++++++++++++
 tb/tb_pwm_capture.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
// A timeout flags a stuck line; results are registered and strobed by o_valid.
module pwm_capture #(
  parameter int CLK_FREQ     = 100000000,
  parameter int PWM_MIN_FREQ = 1000,
  parameter int TIMEOUT_CNT  = CLK_FREQ / PWM_MIN_FREQ,
  parameter int WL           = $clog2(TIMEOUT_CNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pwm,
  output logic [WL-1:0] o_period,
  output logic [WL-1:0] o_high,
  output logic          o_valid,
  output logic          o_stuck,
  output logic          o_level
);

  localparam logic [WL-1:0] TMO = WL'(TIMEOUT_CNT);
  localparam logic [WL-1:0] ONE = WL'(1);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  // Reset asserts immediately but is released on a clock edge.
  logic [1:0] rst_pipe_q;
  logic       rst_core;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe_q <= 2'b11;
    else     rst_pipe_q <= {rst_pipe_q[0], 1'b0};
  end
  assign rst_core = rst_pipe_q[1];

  logic [2:0]    sync_q;
  state_t        state_q, state_d;
  logic [WL-1:0] cnt_q, cnt_d;
  logic [WL-1:0] high_lat_q, high_lat_d;
  logic          fall_seen_q, fall_seen_d;
  logic [WL-1:0] period_q, period_d;
  logic [WL-1:0] high_q, high_d;
  logic          valid_q, valid_d;
  logic          stuck_q, stuck_d;
  logic          level_q, level_d;
  logic          rise, fall, level;

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = rise ? ONE : ((cnt_q == TMO) ? cnt_q : cnt_q + ONE);
    high_lat_d  = high_lat_q;
    fall_seen_d = fall_seen_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    level_d     = level_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d     = ARMED;
          fall_seen_d = 1'b0;
        end
      end
      ARMED, MEASURE: begin
        if (rise) begin
          period_d    = cnt_q;
          high_d      = fall_seen_q ? high_lat_q : cnt_q;
          stuck_d     = 1'b0;
          valid_d     = 1'b1;
          fall_seen_d = 1'b0;
          state_d     = MEASURE;
        end else if (cnt_q == TMO) begin
          // No rise for a whole timeout window: report the stuck level.
          stuck_d  = 1'b1;
          level_d  = level;
          period_d = '0;
          high_d   = '0;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
        if (fall) begin
          high_lat_d  = cnt_q;
          fall_seen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_core) begin
    if (rst_core) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      high_lat_q  <= '0;
      fall_seen_q <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[1:0], i_pwm};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_lat_q  <= high_lat_d;
      fall_seen_q <= fall_seen_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      level_q     <= level_d;
    end
  end

  assign o_period = period_q;
  assign o_high   = high_q;
  assign o_valid  = valid_q;
  assign o_stuck  = stuck_q;
  assign o_level  = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: pulse trains in clk-cycle units, strobes compared with a
// model built from the pulse list (period, high, gap between strobes, timeout).
module tb_pwm_capture;
  localparam int CLK_FREQ     = 1000000;
  localparam int PWM_MIN_FREQ = 2000;
  localparam int TMO          = CLK_FREQ / PWM_MIN_FREQ;
  localparam int WL           = $clog2(TMO + 1);

  typedef struct {
    int cyc;
    int per;
    int hi;
    bit st;
    bit lv;
  } strobe_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_pwm = 1'b0;
  logic [WL-1:0] o_period, o_high;
  logic          o_valid, o_stuck, o_level;

  pwm_capture #(.CLK_FREQ(CLK_FREQ), .PWM_MIN_FREQ(PWM_MIN_FREQ)) dut (
    .clk(clk), .rst(rst), .i_pwm(i_pwm),
    .o_period(o_period), .o_high(o_high), .o_valid(o_valid),
    .o_stuck(o_stuck), .o_level(o_level)
  );

  always #5 clk = ~clk;

  int      cyc = 0;
  int      total = 0;
  int      bad = 0;
  int      t0;
  int      pp[$];
  int      hh[$];
  strobe_t got[$];
  strobe_t exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    strobe_t s;
    if (o_valid === 1'b1) begin
      s.cyc = cyc;
      s.per = int'(o_period);
      s.hi  = int'(o_high);
      s.st  = o_stuck;
      s.lv  = o_level;
      got.push_back(s);
    end
  end

  // Each completed pulse is reported at the next rise, one pulse-period after the
  // previous report; the final pulse never completes, so a timeout report follows
  // TMO cycles after the last good one.
  task automatic build_expect(input bit stuck_lvl);
    strobe_t s;
    exp_q.delete();
    foreach (pp[i]) begin
      s.cyc = (i == 0) ? -1 : pp[i];
      s.per = pp[i];
      s.hi  = hh[i];
      s.st  = 1'b0;
      s.lv  = 1'b0;
      exp_q.push_back(s);
    end
    s.cyc = TMO;
    s.per = 0;
    s.hi  = 0;
    s.st  = 1'b1;
    s.lv  = stuck_lvl;
    exp_q.push_back(s);
  endtask

  task automatic drive_pulse(input int p, input int h);
    i_pwm = 1'b1;
    repeat (h) @(negedge clk);
    i_pwm = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic run_train(input int tail_h);
    got.delete();
    t0 = cyc;
    foreach (pp[i]) drive_pulse(pp[i], hh[i]);
    i_pwm = 1'b1;
    repeat (tail_h) @(negedge clk);
    i_pwm = 1'b0;
    repeat (TMO + 20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_pwm = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (o_period !== '0) begin bad++; $display("FAIL reset_period got=%0d want=0", o_period); end
    total++; if (o_high !== '0) begin bad++; $display("FAIL reset_high got=%0d want=0", o_high); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    total++; if (o_stuck !== 1'b0) begin bad++; $display("FAIL reset_stuck got=%b want=0", o_stuck); end
    total++; if (o_level !== 1'b0) begin bad++; $display("FAIL reset_level got=%b want=0", o_level); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_steady();
    pp.delete(); hh.delete();
    for (int i = 0; i < 6; i++) begin pp.push_back(40); hh.push_back(10); end
    run_train(10);
    build_expect(1'b0);
    total++;
    if (got.size() !== exp_q.size()) begin bad++; $display("FAIL steady_count got=%0d want=%0d", got.size(), exp_q.size()); end
    if (got.size() > 0) begin
      total++;
      if (got[0].cyc - (t0 + pp[0]) < 1 || got[0].cyc - (t0 + pp[0]) > 6) begin
        bad++; $display("FAIL steady_first_strobe got=%0d cycles after 2nd rise want 1..6", got[0].cyc - (t0 + pp[0]));
      end
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i].per !== exp_q[i].per || got[i].hi !== exp_q[i].hi || got[i].st !== exp_q[i].st) begin
        bad++; $display("FAIL steady_val[%0d] got p=%0d h=%0d s=%0b want p=%0d h=%0d s=%0b", i, got[i].per, got[i].hi, got[i].st, exp_q[i].per, exp_q[i].hi, exp_q[i].st);
      end
      if (exp_q[i].st) begin
        total++; if (got[i].lv !== exp_q[i].lv) begin bad++; $display("FAIL steady_level got=%0b want=%0b", got[i].lv, exp_q[i].lv); end
      end
      if (i > 0) begin
        total++;
        if (got[i].cyc - got[i-1].cyc !== exp_q[i].cyc) begin bad++; $display("FAIL steady_gap[%0d] got=%0d want=%0d", i, got[i].cyc - got[i-1].cyc, exp_q[i].cyc); end
      end
    end
  endtask

  task automatic test_duty_sweep();
    int p;
    pp = '{40, 40, 40, 2};
    hh = '{1, 20, 39, 1};
    for (int i = 0; i < 4; i++) begin
      p = int'($urandom_range(120, 4));
      pp.push_back(p);
      hh.push_back(int'($urandom_range(p - 1, 1)));
    end
    run_train(3);
    build_expect(1'b0);
    total++;
    if (got.size() !== exp_q.size()) begin bad++; $display("FAIL sweep_count got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i].per !== exp_q[i].per || got[i].hi !== exp_q[i].hi || got[i].st !== exp_q[i].st) begin
        bad++; $display("FAIL sweep_val[%0d] got p=%0d h=%0d s=%0b want p=%0d h=%0d s=%0b", i, got[i].per, got[i].hi, got[i].st, exp_q[i].per, exp_q[i].hi, exp_q[i].st);
      end
      if (i > 0) begin
        total++;
        if (got[i].cyc - got[i-1].cyc !== exp_q[i].cyc) begin bad++; $display("FAIL sweep_gap[%0d] got=%0d want=%0d", i, got[i].cyc - got[i-1].cyc, exp_q[i].cyc); end
      end
    end
  endtask

  task automatic test_stuck_high();
    pp = '{40, 40};
    hh = '{10, 30};
    run_train(TMO + 10);
    build_expect(1'b1);
    total++;
    if (got.size() !== exp_q.size()) begin bad++; $display("FAIL stuckhi_count got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i].per !== exp_q[i].per || got[i].hi !== exp_q[i].hi || got[i].st !== exp_q[i].st) begin
        bad++; $display("FAIL stuckhi_val[%0d] got p=%0d h=%0d s=%0b want p=%0d h=%0d s=%0b", i, got[i].per, got[i].hi, got[i].st, exp_q[i].per, exp_q[i].hi, exp_q[i].st);
      end
      if (exp_q[i].st) begin
        total++; if (got[i].lv !== 1'b1) begin bad++; $display("FAIL stuckhi_level got=%0b want=1", got[i].lv); end
        total++; if (got[i].cyc - got[i-1].cyc !== TMO) begin bad++; $display("FAIL stuckhi_gap got=%0d want=%0d", got[i].cyc - got[i-1].cyc, TMO); end
      end
    end
  endtask

  task automatic test_resume();
    total++;
    if (o_stuck !== 1'b1) begin bad++; $display("FAIL resume_pre_stuck got=%0b want=1", o_stuck); end
    pp = '{40, 40, 40};
    hh = '{10, 10, 10};
    run_train(10);
    build_expect(1'b0);
    total++;
    if (got.size() !== exp_q.size()) begin bad++; $display("FAIL resume_count got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i].per !== exp_q[i].per || got[i].hi !== exp_q[i].hi || got[i].st !== exp_q[i].st) begin
        bad++; $display("FAIL resume_val[%0d] got p=%0d h=%0d s=%0b want p=%0d h=%0d s=%0b", i, got[i].per, got[i].hi, got[i].st, exp_q[i].per, exp_q[i].hi, exp_q[i].st);
      end
    end
  endtask

  task automatic test_reset_mid();
    got.delete();
    for (int i = 0; i < 3; i++) drive_pulse(40, 15);
    i_pwm = 1'b1;
    repeat (7) @(negedge clk);
    total++;
    if (o_period !== WL'(40)) begin bad++; $display("FAIL rstmid_pre_period got=%0d want=40", o_period); end
    #3 rst = 1'b1;
    #1;
    total++; if (o_period !== '0) begin bad++; $display("FAIL rstmid_period got=%0d want=0", o_period); end
    total++; if (o_high !== '0) begin bad++; $display("FAIL rstmid_high got=%0d want=0", o_high); end
    total++; if (o_valid !== 1'b0 || o_stuck !== 1'b0) begin bad++; $display("FAIL rstmid_flags got v=%b s=%b want 0 0", o_valid, o_stuck); end
    i_pwm = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pp = '{33, 57, 33};
    hh = '{1, 56, 17};
    run_train(4);
    build_expect(1'b0);
    total++;
    if (got.size() !== exp_q.size()) begin bad++; $display("FAIL rstmid_count got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i].per !== exp_q[i].per || got[i].hi !== exp_q[i].hi || got[i].st !== exp_q[i].st) begin
        bad++; $display("FAIL rstmid_val[%0d] got p=%0d h=%0d s=%0b want p=%0d h=%0d s=%0b", i, got[i].per, got[i].hi, got[i].st, exp_q[i].per, exp_q[i].hi, exp_q[i].st);
      end
    end
  endtask

  // Generator at 20 kHz on a 1 MHz clock with duty code 10: low while its
  // counter is below the code, so high time is period minus code.
  task automatic test_loopback();
    localparam int P = CLK_FREQ / 20000;
    localparam int D = 10;
    got.delete();
    for (int k = 0; k < 6 * P; k++) begin
      i_pwm = ((k % P) >= D);
      @(negedge clk);
    end
    i_pwm = 1'b0;
    repeat (TMO + 20) @(negedge clk);
    pp.delete(); hh.delete();
    for (int i = 0; i < 5; i++) begin pp.push_back(P); hh.push_back(P - D); end
    build_expect(1'b0);
    total++;
    if (got.size() !== exp_q.size()) begin bad++; $display("FAIL loop_count got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i].per !== exp_q[i].per || got[i].hi !== exp_q[i].hi || got[i].st !== exp_q[i].st) begin
        bad++; $display("FAIL loop_val[%0d] got p=%0d h=%0d s=%0b want p=%0d h=%0d s=%0b", i, got[i].per, got[i].hi, got[i].st, exp_q[i].per, exp_q[i].hi, exp_q[i].st);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_steady();
    test_duty_sweep();
    test_stuck_high();
    test_resume();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
